mult_seq_ctrl: RTL and testbench

//  FSM controller for the repeated-addition multiplier datapath: A register, B down-counter, product register P, B==0 comparator.

---
 rtl/mult_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Controller for a repeated-addition multiplier: load A, load B/clear P, add-and-decrement until B==0.
// Optional iteration guard is compiled in with `define MULT_ITER_GUARD_EN (sets err on forced abort).
module mult_seq_ctrl #(
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic eqz,
    output logic ld_A,
    output logic ld_B,
    output logic clear_p,
    output logic load_P,
    output logic dec_B,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   guard_trip;

`ifdef MULT_ITER_GUARD_EN
    logic [ITER_W-1:0] iter_cnt_reg;
    logic              err_reg;

    // Counts add iterations of the current operation; restarted when A is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt_reg <= '0;
        end else if (state_reg == LDA) begin
            iter_cnt_reg <= '0;
        end else if (load_P) begin
            iter_cnt_reg <= iter_cnt_reg + 1'b1;
        end
    end

    // The last allowed iteration still adds; the abort takes effect on the following edge.
    assign guard_trip = (state_reg == ADD) && !eqz &&
                        (iter_cnt_reg == ITER_W'(MAX_ITER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (state_reg == ADD) begin
            err_reg <= guard_trip;
        end else if ((state_reg == DONE) && !start) begin
            err_reg <= 1'b0;
        end
    end

    assign err = err_reg;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ITER_W[0], MAX_ITER[0]};
    assign guard_trip = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = LDA;
            LDA:  state_next = LDB;
            LDB:  state_next = ADD;
            ADD: begin
                if (eqz || guard_trip) begin
                    state_next = DONE;
                end
            end
            // Holding start high here must not retrigger; the host has to drop it first.
            DONE: if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ld_A    = 1'b0;
        ld_B    = 1'b0;
        clear_p = 1'b0;
        load_P  = 1'b0;
        dec_B   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_reg)
            LDA: begin
                ld_A = 1'b1;
                busy = 1'b1;
            end
            LDB: begin
                ld_B    = 1'b1;
                clear_p = 1'b1;
                busy    = 1'b1;
            end
            ADD: begin
                busy   = 1'b1;
                load_P = !eqz;
                dec_B  = !eqz;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: drives a small A/B/P datapath model and checks pulse counts, latency and products.
module tb_mult_seq_ctrl;

    localparam int GUARD_MAX = 64;

    logic clk = 1'b0;
    logic rst_n, start, eqz;
    logic ld_A, ld_B, clear_p, load_P, dec_B, busy, done, err;

    logic [15:0] a_reg = '0, b_reg = '0, p_reg = '0;
    logic [15:0] op_a = '0, op_b = '0, bus;
    logic        force_eqz0 = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.ITER_W(16), .MAX_ITER(GUARD_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .eqz(eqz),
        .ld_A(ld_A), .ld_B(ld_B), .clear_p(clear_p), .load_P(load_P),
        .dec_B(dec_B), .busy(busy), .done(done), .err(err)
    );

    // Host puts A on the bus while ld_A is active, otherwise B.
    assign bus = ld_A ? op_a : op_b;
    assign eqz = force_eqz0 ? 1'b0 : (b_reg == 16'd0);

    always @(posedge clk) begin
        if (ld_A) a_reg <= bus;
        if (ld_B) b_reg <= bus;
        else if (dec_B) b_reg <= b_reg - 16'd1;
        if (clear_p) p_reg <= 16'd0;
        else if (load_P) p_reg <= p_reg + a_reg;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_p;
        int          exp_lat;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({ld_A, ld_B, clear_p, load_P, dec_B, busy, done, err});
    endfunction

    // Called mid-cycle; returns edges from the start-sampling edge until done is seen.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit toggle,
                          output int lat, output int pulses, output int nlda, output int nldb);
        op_a = a;
        op_b = b;
        start = 1'b1;
        lat = -1; pulses = 0; nlda = 0; nldb = 0;
        @(posedge clk);
        for (int k = 0; k < 400; k++) begin
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy || (load_P && clear_p) || (ld_A && ld_B) || (load_P != dec_B))
                check("busy_excl", outs(), -1);
            pulses += int'(load_P);
            nlda   += int'(ld_A);
            nldb   += int'(ld_B);
            if (toggle && k >= 2) start = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
    endtask

    task automatic finish_op();
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_done", outs(), 0);
    endtask

    task automatic op_and_check(input string name, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] exp_p, input int exp_lat, input int exp_pulses,
                                input bit toggle);
        int lat, pulses, nlda, nldb;
        run_op(a, b, toggle, lat, pulses, nlda, nldb);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_pulses"}, pulses, exp_pulses);
        check({name, "_ld_A"}, nlda, 1);
        check({name, "_ld_B"}, nldb, 1);
        check({name, "_P"}, int'(p_reg), int'(exp_p));
        check({name, "_err"}, int'(err), 0);
        $display("[TB] %s A=%0d B=%0d P=%0d lat=%0d pulses=%0d", name, a, b, p_reg, lat, pulses);
    endtask

    initial begin
        int lat, pulses, nlda, nldb;
        logic [15:0] ra, rb;

        vecs[0] = '{16'd7,     16'd5, 16'd35,    8, 5};
        vecs[1] = '{16'd9,     16'd0, 16'd0,     3, 0};
        vecs[2] = '{16'd3,     16'd4, 16'd12,    7, 4};
        vecs[3] = '{16'hFFFF,  16'd2, 16'hFFFE,  5, 2};
        vecs[4] = '{16'd1,     16'd1, 16'd1,     4, 1};
        vecs[5] = '{16'd0,     16'd6, 16'd0,     9, 6};

        rst_n = 1'b0;
        start = 1'b0;
        #3;
        check("reset_async_outs", outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_outs", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start", outs(), 0);

        for (int i = 0; i < 6; i++) begin
            op_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_p,
                         vecs[i].exp_lat, vecs[i].exp_pulses, 1'b0);
            if (i == 0) begin
                int ld_seen = 0;
                int done_lost = 0;
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk);
                    #1;
                    ld_seen   += int'(ld_A);
                    done_lost += int'(!done);
                end
                check("hold_start_no_retrigger", ld_seen, 0);
                check("hold_start_done_stays", done_lost, 0);
            end
            finish_op();
        end

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 40));
            op_and_check($sformatf("rand%0d", i), ra, rb, 16'((int'(ra) * int'(rb)) & 32'hFFFF),
                         int'(rb) + 3, int'(rb), 1'b0);
            finish_op();
        end

        op_and_check("toggle_start", 16'd5, 16'd6, 16'd30, 9, 6, 1'b1);
        finish_op();

        op_a = 16'd2;
        op_b = 16'd10;
        start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3;
        check("pre_reset_in_add", int'({busy, load_P}), 3);
        rst_n = 1'b0;
        #1;
        check("reset_mid_add", outs(), 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid_add_held", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", outs(), 0);
        op_and_check("after_reset", 16'd3, 16'd3, 16'd9, 6, 3, 1'b0);
        finish_op();

        force_eqz0 = 1'b1;
`ifdef MULT_ITER_GUARD_EN
        run_op(16'd1, 16'd2, 1'b0, lat, pulses, nlda, nldb);
        check("guard_pulses", pulses, GUARD_MAX);
        check("guard_lat", lat, GUARD_MAX + 2);
        check("guard_err", int'(err), 1);
        $display("[TB] guard lat=%0d pulses=%0d err=%0d", lat, pulses, err);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("guard_err_clear", int'({err, done, busy}), 0);
`else
        begin
            int seen_done = 0;
            int seen_err  = 0;
            op_a = 16'd1;
            op_b = 16'd2;
            start = 1'b1;
            pulses = 0;
            @(posedge clk);
            for (int k = 0; k < GUARD_MAX + 30; k++) begin
                #1;
                pulses    += int'(load_P);
                seen_done += int'(done);
                seen_err  += int'(err);
                @(posedge clk);
            end
            check("noguard_pulses", pulses, GUARD_MAX + 28);
            check("noguard_done", seen_done, 0);
            check("noguard_err", seen_err, 0);
            $display("[TB] no-guard pulses=%0d done=%0d err=%0d", pulses, seen_done, seen_err);
            #1;
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            check("noguard_reset_exit", outs(), 0);
            @(negedge clk);
            rst_n = 1'b1;
        end
`endif
        force_eqz0 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
